// File: rtl/spi_flash_read_cache.sv
// Direct-mapped, one-word-per-line read cache in front of the SPI flash
// controller. A hit returns data one cycle after rstrb. A miss runs one flash
// read (ISSUE -> WAIT) and fills the line. rstrb/rbusy follow the FemtoRV32
// convention.
module spi_flash_read_cache #(
    parameter int INDEX_BITS = 3,
    parameter int ADDR_BITS  = 20,
    parameter int CNT_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rstrb,
    input  logic [ADDR_BITS-1:0] word_address,
    output logic [31:0]          rdata,
    output logic                 rbusy,
    input  logic                 inv,
    output logic                 fl_rstrb,
    output logic [ADDR_BITS-1:0] fl_word_address,
    input  logic [31:0]          fl_rdata,
    input  logic                 fl_rbusy,
    output logic [CNT_BITS-1:0]  hit_count,
    output logic [CNT_BITS-1:0]  miss_count
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state, next_state;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    // Latched miss address; it also drives the flash controller address.
    logic [ADDR_BITS-1:0] addr_q;
    // Cleared by an invalidate that lands while a fill is in flight, so the
    // returning word is handed to the CPU but not marked valid.
    logic                 fill_ok;
    // High during the first WAIT cycle, when the controller has not yet
    // had the chance to raise its busy flag.
    logic                 wait_first;

    logic                  hit, miss, fill;
    logic [INDEX_BITS-1:0] index, fill_index;
    logic [TAG_BITS-1:0]   tag, fill_tag;
    logic                  lookup_hit;

    assign index           = word_address[INDEX_BITS-1:0];
    assign tag             = word_address[ADDR_BITS-1:INDEX_BITS];
    assign fill_index      = addr_q[INDEX_BITS-1:0];
    assign fill_tag        = addr_q[ADDR_BITS-1:INDEX_BITS];
    assign lookup_hit      = valid[index] && (tag_mem[index] == tag);
    assign fl_word_address = addr_q;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_BITS'(1);
    endfunction

    // State register; reset aborts any fill in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, lookup decision and the flash strobe.
    always_comb begin
        next_state = state;
        hit        = 1'b0;
        miss       = 1'b0;
        fill       = 1'b0;
        fl_rstrb   = 1'b0;
        case (state)
            IDLE: begin
                if (rstrb) begin
                    // An invalidate in the same cycle forces a miss.
                    if (!inv && lookup_hit) begin
                        hit = 1'b1;
                    end else begin
                        miss       = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                fl_rstrb   = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (!wait_first && !fl_rbusy) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Control registers: valid bits, CPU-side outputs, miss address, counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid      <= '0;
            rdata      <= '0;
            rbusy      <= 1'b0;
            addr_q     <= '0;
            fill_ok    <= 1'b0;
            wait_first <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            wait_first <= (state == ISSUE);

            if (inv) begin
                valid <= '0;
            end else if (fill && fill_ok) begin
                valid[fill_index] <= 1'b1;
            end

            if (miss) begin
                addr_q     <= word_address;
                rbusy      <= 1'b1;
                fill_ok    <= 1'b1;
                miss_count <= sat_inc(miss_count);
            end else if (inv) begin
                fill_ok <= 1'b0;
            end

            if (hit) begin
                rdata     <= data_mem[index];
                hit_count <= sat_inc(hit_count);
            end

            if (fill) begin
                rdata <= fl_rdata;
                rbusy <= 1'b0;
            end
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= fl_rdata;
        end
    end

endmodule
